// File: rtl/seq_mul_acc_pkg.sv
// Shared definitions for the sequential multiplier and its accumulator stage.
package seq_mul_pkg;

    // Product width produced by seq_mul (its op output), reused downstream.
    localparam int SEQ_MUL_OP_W = 8;

    // Accumulator defaults.
    localparam int PROD_W_DEF  = SEQ_MUL_OP_W;
    localparam int ACC_W_DEF   = 12;
    localparam int N_TERMS_DEF = 4;

    // ACCUM: collecting terms. HOLD: completed sum waiting for downstream ack.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/seq_mul_acc_rise_detect.sv
// One-bit rising-edge detector. The previous level is registered; its reset
// value is a parameter so a level already high at reset release can be
// treated as "old" (RST_VAL=1) and not produce an event.
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;

    // Remember the previous level every cycle, regardless of what the consumer does.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/seq_mul_acc.sv
// Multiply-accumulate back end: sums N_TERMS consecutive products from seq_mul
// (one per rising edge of its ready_out) and offers the sum downstream.
//
// Handshake: sum_valid rises with a completed sum and stays high, with sum_out
// stable, until a cycle in which sum_ack=1; sum_valid falls in the next cycle.
// sum_ack while sum_valid=0 has no effect. There is no back-pressure toward the
// multiplier: products arriving while a sum is held are dropped and flagged.
module seq_mul_acc
    import seq_mul_pkg::*;
#(
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int N_TERMS = N_TERMS_DEF
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_rdy,
    input  logic              clr,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_valid,
    input  logic              sum_ack,
    output logic [7:0]        term_cnt,
    output logic              ovf,
    output logic              drop,
    output logic              state_dbg
);

    localparam int             EXT_W  = ACC_W - PROD_W + 1;
    localparam logic [7:0]     N_LAST = 8'(N_TERMS);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             drop_q, drop_d;

    logic             prod_ev;
    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   add_w;
    logic [7:0]       cnt_inc;

    // Previous ready level resets high so a ready_out already high is not a product.
    rise_detect #(
        .RST_VAL (1'b1)
    ) u_rise (
        .clk_i   (clk),
        .rst_i   (rst_a),
        .level_i (prod_rdy),
        .rise_o  (prod_ev)
    );

    assign prod_ext = {{EXT_W{1'b0}}, prod_in};
    assign add_w    = {1'b0, acc_q} + prod_ext;
    assign cnt_inc  = cnt_q + 8'd1;

    // Next-state logic: clr overrides everything; otherwise ACCUM sums, HOLD waits for ack.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;

        if (clr) begin
            // A product event this cycle is silently discarded.
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
            drop_d  = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (prod_ev) begin
                        acc_d = add_w[ACC_W-1:0];
                        cnt_d = cnt_inc;
                        if (add_w[ACC_W]) begin
                            ovf_d = 1'b1;
                        end
                        if (cnt_inc == N_LAST) begin
                            sum_d   = add_w[ACC_W-1:0];
                            valid_d = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (sum_ack) begin
                        if (prod_ev) begin
                            // The coincident product opens the next sum as term 1.
                            acc_d = prod_ext[ACC_W-1:0];
                            cnt_d = 8'd1;
                            if (N_LAST == 8'd1) begin
                                // Single-term sums complete immediately.
                                sum_d   = prod_ext[ACC_W-1:0];
                                valid_d = 1'b1;
                                state_d = HOLD;
                            end else begin
                                valid_d = 1'b0;
                                state_d = ACCUM;
                            end
                        end else begin
                            acc_d   = '0;
                            cnt_d   = '0;
                            valid_d = 1'b0;
                            state_d = ACCUM;
                        end
                    end else if (prod_ev) begin
                        drop_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    // State and datapath registers; reset has priority over clr.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign sum_out   = sum_q;
    assign sum_valid = valid_q;
    assign term_cnt  = cnt_q;
    assign ovf       = ovf_q;
    assign drop      = drop_q;
    assign state_dbg = state_q;

endmodule

// File: doc/seq_mul_acc.md
# seq_mul_acc

Accumulator stage that sits directly downstream of the 4-bit sequential multiplier `seq_mul`. It captures each completed product (on the rising edge of the multiplier's `ready_out`), sums a fixed number of consecutive products, and presents the finished sum to the next stage with a valid/ack handshake. Together with the multiplier it forms a multiply-accumulate (dot-product) path.

## Interface
- `PROD_W`, 8, product width; matches the multiplier `op` width.
- `ACC_W`, 12, accumulator and sum width; must be ≥ `PROD_W`.
- `N_TERMS`, 4, number of products per sum; range 1..255.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst_a`  in  1  reset. It is synchronous and active-high.
- `prod_in`  in  `PROD_W`  product, driven from multiplier `op`.
- `prod_rdy`  in  1  from multiplier `ready_out`; may be a level or a pulse.
- `clr`  in  1  synchronous abort/restart of the current sum.
- `sum_out`  out  `ACC_W`  completed sum; stable while `sum_valid`=1.
- `sum_valid`  out  1  a completed sum is held.
- `sum_ack`  in  1  downstream accepts the sum.
- `term_cnt`  out  8  products accumulated into the current sum.
- `ovf`  out  1  sticky flag: carry out of the accumulator since the last clr/reset.
- `drop`  out  1  sticky flag: a product arrived while in HOLD and was discarded.

## Operation
- Product event: `prod_rdy`=1 this cycle and the registered previous value `prev_rdy`=0. Only edges count, so a level held high gives exactly one event.
- States:
  - ACCUM (reset state).
    - On a product event: acc ← acc + zero-extended `prod_in` (mod 2^`ACC_W`) and `term_cnt`++.
    - If that add yields a carry-out, `ovf` ← 1.
    - If this is term `N_TERMS`: `sum_out` ← the new sum, `sum_valid` ← 1, go to HOLD.
  - HOLD.
    - `sum_out` and `sum_valid` are held until `sum_ack`=1.
    - On ack: `sum_valid` ← 0, acc ← 0, `term_cnt` ← 0, go to ACCUM.
    - A product event without ack: the product is discarded and `drop` ← 1.
    - A product event in the same cycle as ack: the product becomes term 1 of the next sum (acc ← prod, `term_cnt` ← 1). It is not dropped.
- `clr` (priority below reset, above everything else):
  - acc, `term_cnt`, `sum_valid`, `ovf` and `drop` ← 0; go to ACCUM.
  - A product event in the same cycle as `clr` is discarded without setting `drop`.
  - `prev_rdy` still updates, so a level that stays high is not re-counted.
- `sum_ack` while `sum_valid`=0 is ignored.
- Reset values:
  - state = ACCUM; acc, `sum_out`, `term_cnt` = 0.
  - `sum_valid`, `ovf`, `drop` = 0.
  - `prev_rdy` = 1, so a `ready_out` already high at reset release is not counted as a product.

## Timing
- `prev_rdy` is registered. A product is sampled in the event cycle; `term_cnt` and acc reflect it from the next cycle.
- Latency: `sum_valid` rises 1 cycle after the cycle containing the `N_TERMS`-th product event.
- Ack: `sum_valid` falls 1 cycle after the `sum_ack` cycle. The minimum HOLD occupancy is 1 cycle (ack in the first valid cycle).
- Back-to-back: the earliest next product event is 2 cycles after the previous one, because a rise needs a low in between. No stall path exists toward the multiplier; the multiplier is never throttled, so products that arrive in HOLD are lost and reported via `drop`.
- `N_TERMS`=1: every product event goes directly ACCUM→HOLD.
- Mid-operation reset or `clr`: the partial sum is lost. There is no partial output.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `seq_mul_pkg`:
  - state typedef (ACCUM, HOLD);
  - default `PROD_W`/`ACC_W`/`N_TERMS` constants;
  - a shared product-width constant also used by the multiplier.
- Sub-module `rise_detect`: 1-bit registered edge detector with a parameterised reset value (here 1). It outputs the single-cycle event.
- The remainder (FSM, adder with carry, counters, flags) stays in `seq_mul_acc`.

## Test plan
- Reset with `prod_rdy` held 1 through release, then held: no event, `term_cnt`=0, all outputs 0.
- Defaults, products 6, 9, 4, 1 as separated pulses:
  - `sum_valid` rises 1 cycle after the 4th pulse with `sum_out`=20 (0x014), `ovf`=0;
  - ack → `sum_valid`=0 next cycle, `term_cnt`=0.
- `ACC_W`=9, four products of 225:
  - `sum_out`=388 (900 mod 512), `ovf`=1;
  - `ovf` stays 1 after ack and clears only on `clr`.
- In HOLD with sum 20, product 9 arrives with no ack: `drop`=1, `sum_out` stays 20. Then ack in the same cycle as product 6: `sum_valid`=0, `term_cnt`=1, and the next sum starts with 6.
- `clr` after 2 products (6, 9), with a product event on the `clr` cycle:
  - `term_cnt`=0 next cycle and the product is ignored;
  - then 2, 3, 4, 5 → `sum_out`=14.
- `N_TERMS`=1, products 9 then 4, each acked:
  - two sums, 9 and 4;
  - `sum_valid` deasserts for ≥1 cycle between them.
